// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared Ascon-p configuration, FSM states and state struct
package config_pkg;

  // Rounds evaluated per clock by asconp; must divide every round count in use.
  localparam int UROL = 1;

  localparam int ROUNDS_A  = 12;
  localparam int ROUNDS_B  = 8;
  localparam int ROUNDS_B6 = 6;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  function automatic logic rounds_legal(input logic [3:0] r);
    logic known;
    known = (r == 4'(ROUNDS_A)) || (r == 4'(ROUNDS_B)) || (r == 4'(ROUNDS_B6));
    return known && ((int'(r) % UROL) == 0);
  endfunction

endpackage

// File: rtl/asconp.sv
// rtl/asconp.sv - combinational Ascon-p core, UROL rounds starting at round_cnt
module asconp
  import config_pkg::*;
(
  input  logic [3:0]   round_cnt,
  input  ascon_state_t state_in,
  output ascon_state_t state_out
);

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic ascon_state_t round_fn(input ascon_state_t s, input logic [3:0] idx);
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    ascon_state_t r;
    a0 = s.x0 ^ s.x4;
    a1 = s.x1;
    a2 = s.x2 ^ {56'd0, 4'hF - idx, idx} ^ s.x1;
    a3 = s.x3;
    a4 = s.x4 ^ s.x3;
    b0 = a0 ^ (~a1 & a2);
    b1 = a1 ^ (~a2 & a3);
    b2 = a2 ^ (~a3 & a4);
    b3 = a3 ^ (~a4 & a0);
    b4 = a4 ^ (~a0 & a1);
    b1 = b1 ^ b0;
    b0 = b0 ^ b4;
    b3 = b3 ^ b2;
    b2 = ~b2;
    r.x0 = b0 ^ ror(b0, 19) ^ ror(b0, 28);
    r.x1 = b1 ^ ror(b1, 61) ^ ror(b1, 39);
    r.x2 = b2 ^ ror(b2, 1)  ^ ror(b2, 6);
    r.x3 = b3 ^ ror(b3, 10) ^ ror(b3, 17);
    r.x4 = b4 ^ ror(b4, 7)  ^ ror(b4, 41);
    return r;
  endfunction

  ascon_state_t acc;

  // Round index counts up from 12 - round_cnt, which selects the constant.
  always_comb begin
    acc = state_in;
    for (int u = 0; u < UROL; u++) begin
      acc = round_fn(acc, 4'd12 - round_cnt + 4'(u));
    end
    state_out = acc;
  end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// rtl/ascon_perm_ctrl.sv - request/iterate/return sequencer around asconp
module ascon_perm_ctrl
  import config_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_rounds,
  input  logic [63:0] in_x0,
  input  logic [63:0] in_x1,
  input  logic [63:0] in_x2,
  input  logic [63:0] in_x3,
  input  logic [63:0] in_x4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_x0,
  output logic [63:0] out_x1,
  output logic [63:0] out_x2,
  output logic [63:0] out_x3,
  output logic [63:0] out_x4,
  output logic        busy,
  output logic        err
);

  localparam logic [3:0] STEP = 4'(UROL);

  state_t       state, state_nxt;
  logic [3:0]   round_cnt;
  ascon_state_t regs, perm_out, in_state;
  logic         legal, accept, load;

  assign in_state = '{x0: in_x0, x1: in_x1, x2: in_x2, x3: in_x3, x4: in_x4};
  assign legal    = rounds_legal(in_rounds);

  asconp u_asconp (
    .round_cnt (round_cnt),
    .state_in  (regs),
    .state_out (perm_out)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && legal) state_nxt = RUN;
      end
      RUN: begin
        if (round_cnt <= STEP) state_nxt = DONE;
      end
      DONE: begin
        // Releasing the result and taking the next request share one cycle.
        if (out_ready) begin
          in_ready  = 1'b1;
          state_nxt = (in_valid && legal) ? RUN : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) in_ready = 1'b0;
  end

  assign accept    = in_valid & in_ready;
  assign load      = accept & legal;
  assign err       = accept & ~legal;
  assign out_valid = (state == DONE) & ~rst;
  assign busy      = (state == RUN) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      round_cnt <= 4'd0;
      regs      <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        regs      <= in_state;
        round_cnt <= in_rounds;
      end else if (state == RUN && round_cnt >= STEP) begin
        regs      <= perm_out;
        round_cnt <= round_cnt - STEP;
      end
    end
  end

  assign out_x0 = regs.x0;
  assign out_x1 = regs.x1;
  assign out_x2 = regs.x2;
  assign out_x3 = regs.x3;
  assign out_x4 = regs.x4;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// tb/tb_ascon_perm_ctrl.sv - randomized self-checking bench with transaction-level Ascon-p model
module tb_ascon_perm_ctrl;
  import config_pkg::UROL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_rounds = 4'd12;
  logic [63:0] in_x0 = '0, in_x1 = '0, in_x2 = '0, in_x3 = '0, in_x4 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_x0, out_x1, out_x2, out_x3, out_x4;
  logic        busy, err;
  logic [319:0] dut_x;

  ascon_perm_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rounds(in_rounds),
    .in_x0(in_x0), .in_x1(in_x1), .in_x2(in_x2), .in_x3(in_x3), .in_x4(in_x4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x0(out_x0), .out_x1(out_x1), .out_x2(out_x2), .out_x3(out_x3), .out_x4(out_x4),
    .busy(busy), .err(err)
  );

  assign dut_x = {out_x0, out_x1, out_x2, out_x3, out_x4};

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Ascon-p written as in the reference C code, words in an array.
  function automatic logic [319:0] model_perm(input logic [319:0] s, input int r);
    logic [63:0] x[5];
    logic [63:0] t[5];
    int rot_a[5] = '{19, 61, 1, 10, 7};
    int rot_b[5] = '{28, 39, 6, 17, 41};
    for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
    for (int i = 12 - r; i < 12; i++) begin
      x[2] ^= 64'(((15 - i) << 4) | i);
      x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
      for (int k = 0; k < 5; k++) t[k] = ~x[k] & x[(k + 1) % 5];
      for (int k = 0; k < 5; k++) x[k] ^= t[(k + 1) % 5];
      x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
      for (int k = 0; k < 5; k++) x[k] ^= rotr(x[k], rot_a[k]) ^ rotr(x[k], rot_b[k]);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic bit model_legal(input logic [3:0] r);
    int v;
    v = int'(r);
    return (v == 12 || v == 8 || v == 6) && (v % UROL == 0);
  endfunction

  localparam logic [319:0] HASH_IV_IN  = {64'h00400c0000000100, 256'd0};
  localparam logic [319:0] HASH_IV_OUT = {64'hee9398aadb67f03d, 64'h8bb21831c60f1002,
                                         64'hb48a92db98d5da62, 64'h43189921b8f8e3e8,
                                         64'h348fa5c9d525e140};

  // Transaction model: one outstanding permutation, ready R/UROL+1 cycles after its accept cycle.
  int           cyc = 0;
  bit           pending = 1'b0;
  int           ready_cyc = 0;
  logic [319:0] exp_reg = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    bit ev, eb, eir, ee, lg;
    lg  = model_legal(in_rounds);
    ev  = !rst && pending && (cyc >= ready_cyc);
    eb  = !rst && pending && (cyc < ready_cyc);
    eir = !rst && (!pending || (ev && out_ready));
    ee  = eir && in_valid && !lg;
    chk1("in_ready", in_ready, eir);
    chk1("out_valid", out_valid, ev);
    chk1("busy", busy, eb);
    chk1("err", err, ee);
    if (!rst && !eb) chkw("out_x", dut_x, exp_reg);
    if (rst) begin
      pending = 1'b0;
      exp_reg = '0;
    end else begin
      if (ev && out_ready) pending = 1'b0;
      if (eir && in_valid && lg) begin
        pending   = 1'b1;
        ready_cyc = cyc + int'(in_rounds) / UROL + 1;
        exp_reg   = model_perm({in_x0, in_x1, in_x2, in_x3, in_x4}, int'(in_rounds));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [319:0] s, input logic [3:0] r, input bit keep, output int acc);
    bit fired;
    {in_x0, in_x1, in_x2, in_x3, in_x4} = s;
    in_rounds = r;
    in_valid  = 1'b1;
    acc = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      fired = in_ready;
      if (fired) acc = cyc;
      step();
      if (fired) break;
    end
    if (acc < 0) chk1("send_timeout", 1'b0, 1'b1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int at);
    at = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (out_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk1("wait_out_valid_timeout", 1'b0, 1'b1);
  endtask

  function automatic logic [319:0] rnd_state();
    return {$urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [3:0] rnd_rounds();
    logic [3:0] pick[4] = '{4'd12, 4'd8, 4'd6, 4'd7};
    if ($urandom_range(0, 7) == 0) return 4'($urandom);
    return pick[$urandom_range(0, 3)];
  endfunction

  initial begin
    int a1, a2, v;
    logic [319:0] held;

    chkw("model_hash_iv_p12", model_perm(HASH_IV_IN, 12), HASH_IV_OUT);
    chkw("model_p0_identity", model_perm(HASH_IV_IN, 0), HASH_IV_IN);

    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk1("reset_in_ready", in_ready, 1'b1);
    chkw("reset_state", dut_x, 320'd0);
    step();

    send(HASH_IV_IN, 4'd12, 1'b0, a1);
    wait_valid(v);
    chkw("hash_iv_dut", dut_x, HASH_IV_OUT);
    chkw("p12_latency", 320'(v - a1), 320'(12 / UROL + 1));
    step();

    send({64'h80400c0600000000, 256'd0}, 4'd12, 1'b0, a1);
    wait_valid(v);
    step();

    if (8 % UROL == 0) begin
      send(rnd_state(), 4'd8, 1'b1, a1);
      send(rnd_state(), 4'd6, 1'b0, a2);
      chkw("back_to_back_spacing", 320'(a2 - a1), 320'(8 / UROL + 1));
      wait_valid(v);
      step();
    end

    out_ready = 1'b0;
    send(rnd_state(), 4'd12, 1'b0, a1);
    wait_valid(v);
    held = dut_x;
    step();
    {in_x0, in_x1, in_x2, in_x3, in_x4} = rnd_state();
    in_rounds = 4'd6;
    in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chkw("done_hold_stable", dut_x, held);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();

    send(rnd_state(), 4'd7, 1'b0, a1);
    step();
    if (UROL == 3) begin
      send(rnd_state(), 4'd8, 1'b0, a1);
      step();
    end

    send(rnd_state(), 4'd12, 1'b0, a1);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    send(rnd_state(), 4'd12, 1'b0, a1);
    wait_valid(v);
    step();

    send(rnd_state(), 4'd12, 1'b0, a1);
    for (int k = 0; k < 12 / UROL - 1; k++) begin
      in_valid  = 1'($urandom);
      {in_x0, in_x1, in_x2, in_x3, in_x4} = rnd_state();
      in_rounds = rnd_rounds();
      step();
    end
    in_valid = 1'b0;
    wait_valid(v);
    chkw("noisy_run_latency", 320'(v - a1), 320'(12 / UROL + 1));
    step();

    for (int k = 0; k < 3000; k++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_rounds = rnd_rounds();
      {in_x0, in_x1, in_x2, in_x3, in_x4} = rnd_state();
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
